// File: rtl/mem_stage_access.sv
// Memory-stage access controller: EX/MEM operands to a req/ready data-memory bus.
// Optional bus watchdog compiled in with `define MEM_TIMEOUT_EN.
module mem_stage_access #(
  parameter logic [1:0]  LOAD_SRC       = 2'b01,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWriteM,
  input  logic [1:0]  resultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] writeDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic [31:0] readDataM,
  output logic        readValidM,
  output logic        excM,
  output logic        busErrM
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic [31:0] r_read_data;
  logic        r_read_valid;
  logic        r_bus_err;

  logic        w_is_store;
  logic        w_is_load;
  logic        w_valid;
  logic        w_size_ok;
  logic        w_misaligned;
  logic        w_legal;
  logic        w_accept;
  logic        w_in_access;
  logic        w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  // Store has priority when both store and load are flagged.
  assign w_is_store = memWriteM;
  assign w_is_load  = !memWriteM && (resultSrcM == LOAD_SRC);
  assign w_valid    = w_is_store || w_is_load;

  always_comb begin
    w_size_ok = 1'b0;
    case (funct3M)
      3'b000, 3'b001, 3'b010: w_size_ok = 1'b1;
      3'b100, 3'b101:         w_size_ok = w_is_load;
      default:                w_size_ok = 1'b0;
    endcase
  end

  assign w_misaligned = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                        ((funct3M == 3'b010) && (ALUResultM[1:0] != 2'b00));
  assign w_legal      = w_size_ok && !w_misaligned;
  assign w_in_access  = (r_state == S_ACCESS);

  // Reset gates the combinational outputs so nothing is accepted during reset.
  assign w_accept = rst && (r_state == S_IDLE) && w_valid && w_legal;
  assign excM     = rst && (r_state == S_IDLE) && w_valid && !w_legal;
  assign stallM   = rst && (w_accept || w_in_access);

  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = writeDataM;
    case (funct3M[1:0])
      2'b00: begin
        w_st_be    = 4'b0001 << ALUResultM[1:0];
        w_st_wdata = {4{writeDataM[7:0]}};
      end
      2'b01: begin
        w_st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{writeDataM[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = writeDataM;
      end
    endcase
  end

  always_comb begin
    w_ld_byte = dmem_rdata[7:0];
    case (r_offset)
      2'd0: w_ld_byte = dmem_rdata[7:0];
      2'd1: w_ld_byte = dmem_rdata[15:8];
      2'd2: w_ld_byte = dmem_rdata[23:16];
      2'd3: w_ld_byte = dmem_rdata[31:24];
      default: w_ld_byte = dmem_rdata[7:0];
    endcase
    w_ld_half = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b100:  w_ld_data = {24'h000000, w_ld_byte};
      3'b101:  w_ld_data = {16'h0000, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = TIMEOUT_CYCLES[9:0];

  logic [9:0] r_tmo_cnt;

  // Counts ACCESS cycles without ready; fires on the cycle that would reach the limit.
  assign w_timeout = w_in_access && !dmem_ready && ((r_tmo_cnt + 10'd1) == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt <= 10'd0;
    end else if (w_accept) begin
      r_tmo_cnt <= 10'd0;
    end else if (w_in_access && !dmem_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 10'd1;
    end
  end
`else
  logic [9:0] w_unused_tmo;

  assign w_unused_tmo = TIMEOUT_CYCLES[9:0];
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_ACCESS;
      S_ACCESS: if (dmem_ready || w_timeout) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_be         <= 4'h0;
      r_wdata      <= 32'h0;
      r_funct3     <= 3'b000;
      r_offset     <= 2'b00;
      r_read_data  <= 32'h0;
      r_read_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_read_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      if (w_accept) begin
        r_req    <= 1'b1;
        r_we     <= w_is_store;
        r_addr   <= {ALUResultM[31:2], 2'b00};
        r_be     <= w_is_store ? w_st_be : 4'b1111;
        r_wdata  <= w_is_store ? w_st_wdata : 32'h0;
        r_funct3 <= funct3M;
        r_offset <= ALUResultM[1:0];
      end else if (w_in_access) begin
        if (dmem_ready) begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
          if (!r_we) begin
            r_read_data  <= w_ld_data;
            r_read_valid <= 1'b1;
          end
        end else if (w_timeout) begin
          // Abandon the access; readDataM keeps its last loaded value.
          r_req     <= 1'b0;
          r_we      <= 1'b0;
          r_bus_err <= 1'b1;
        end
      end
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign readDataM  = r_read_data;
  assign readValidM = r_read_valid;
  assign busErrM    = r_bus_err;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed cases plus randomized ops
// checked against a size/alignment reference model.
module tb_mem_stage_access;

  localparam int LIMIT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        memWriteM;
  logic [1:0]  resultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] writeDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stallM;
  logic [31:0] readDataM;
  logic        readValidM;
  logic        excM;
  logic        busErrM;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Observations from the last access
  int          obs_stall, obs_exc, obs_req, obs_buserr, obs_start, obs_done;
  bit          obs_hung, obs_stable, obs_rvalid;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we;
  logic [31:0] m_last;

  mem_stage_access #(
    .LOAD_SRC       (2'b01),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memWriteM  (memWriteM),
    .resultSrcM (resultSrcM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .writeDataM (writeDataM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .stallM     (stallM),
    .readDataM  (readDataM),
    .readValidM (readValidM),
    .excM       (excM),
    .busErrM    (busErrM)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int m_bytes(input bit st, input logic [2:0] f3);
    case (f3)
      3'b000: return 1;
      3'b001: return 2;
      3'b010: return 4;
      3'b100: return st ? 0 : 1;
      3'b101: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = m_bytes(st, f3);
    if (n == 0) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [3:0] mask;
    if (!st) return 4'hF;
    n = m_bytes(st, f3);
    mask = 4'((1 << n) - 1);
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    logic [31:0] mask, r;
    n = m_bytes(1'b1, f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 1);
    r = 32'h0;
    for (int i = 0; i < 4 / n; i++) r = r | ((wd & mask) << (8 * n * i));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] mask, v;
    n = m_bytes(1'b0, f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 1);
    v = (rd >> (8 * (a % 4))) & mask;
    if (n < 4 && f3[2] == 1'b0 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drop_op();
    memWriteM  = 1'b0;
    resultSrcM = 2'b00;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    writeDataM = 32'h0;
  endtask

  task automatic do_access(input bit st, input bit ld, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits);
    int acc;
    bit done;
    acc = 0; done = 0;
    obs_stall = 0; obs_exc = 0; obs_req = 0; obs_buserr = 0; obs_hung = 0;
    obs_stable = 1; obs_rvalid = 0; obs_addr = 'x; obs_wdata = 'x; obs_be = 'x; obs_we = 'x;
    obs_rdata = 'x;
    @(posedge clk); #1;
    memWriteM  = st;
    resultSrcM = ld ? 2'b01 : 2'b00;
    funct3M    = f3;
    ALUResultM = addr;
    writeDataM = wd;
    dmem_ready = 1'b0;
    dmem_rdata = $urandom;
    #1;
    obs_start = cyc;
    obs_stall += int'(stallM);
    obs_exc   += int'(excM);
    if (!stallM) begin
      @(posedge clk); #1;
      drop_op();
      #1;
      obs_req += int'(dmem_req);
      obs_exc += int'(excM);
      obs_rdata = readDataM;
      obs_done = cyc;
      return;
    end
    for (int c = 0; c < LIMIT; c++) begin
      @(posedge clk); #1;
      obs_buserr += int'(busErrM);
      if (dmem_req) begin
        acc++;
        obs_req++;
        if (acc == 1) begin
          obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
        end else if (dmem_addr !== obs_addr || dmem_be !== obs_be ||
                     dmem_wdata !== obs_wdata || dmem_we !== obs_we) begin
          obs_stable = 0;
        end
        obs_rvalid = obs_rvalid | readValidM;
        dmem_ready = (acc > waits);
        dmem_rdata = dmem_ready ? rd : $urandom;
        #1;
        obs_stall += int'(stallM);
        obs_exc   += int'(excM);
      end else begin
        dmem_ready = 1'b0;
        obs_rvalid = readValidM;
        obs_rdata  = readDataM;
        obs_done   = cyc;
        drop_op();
        #1;
        obs_stall += int'(stallM);
        obs_exc   += int'(excM);
        done = 1;
        break;
      end
    end
    if (!done) obs_hung = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drop_op();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    memWriteM = 1'b1; funct3M = 3'b000; ALUResultM = 32'h10; #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stallM); end
    funct3M = 3'b011; #1;
    checks++; if (excM !== 1'b0) begin errors++; $display("FAIL rst_exc: got %b expected 0", excM); end
    checks++; if ({dmem_req, dmem_we, readValidM, busErrM} !== 4'b0000) begin errors++;
      $display("FAIL rst_ctl: got %b expected 0000", {dmem_req, dmem_we, readValidM, busErrM}); end
    checks++; if ({dmem_addr, dmem_be, dmem_wdata, readDataM} !== 100'h0) begin errors++;
      $display("FAIL rst_data: got %h/%h/%h/%h expected zeros", dmem_addr, dmem_be, dmem_wdata, readDataM); end
    drop_op();
    rst = 1'b1;
    m_last = 32'h0;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_sb();
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
    checks++; if (obs_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", obs_be); end
    checks++; if (obs_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", obs_wdata); end
    checks++; if (obs_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", obs_addr); end
    checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", obs_we); end
    checks++; if (obs_stall !== 2) begin errors++; $display("FAIL sb_stall: got %0d expected 2", obs_stall); end
    checks++; if (obs_rvalid !== 1'b0) begin errors++; $display("FAIL sb_rvalid: got %b expected 0", obs_rvalid); end
    $display("SB  addr=00001003 be=%b wdata=%h stall=%0d", obs_be, obs_wdata, obs_stall);
  endtask

  task automatic test_loads();
    do_access(1'b0, 1'b1, 3'b000, 32'h0000_2002, 32'h0, 32'h00F0_0000, 0);
    checks++; if (obs_rdata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data: got %h expected fffffff0", obs_rdata); end
    checks++; if (obs_rvalid !== 1'b1) begin errors++; $display("FAIL lb_rvalid: got %b expected 1", obs_rvalid); end
    checks++; if (obs_be !== 4'hF) begin errors++; $display("FAIL lb_be: got %b expected 1111", obs_be); end
    @(posedge clk); #1;
    checks++; if (readValidM !== 1'b0) begin errors++; $display("FAIL lb_pulse: got %b expected 0", readValidM); end
    $display("LB  addr=00002002 data=%h", obs_rdata);
    do_access(1'b0, 1'b1, 3'b100, 32'h0000_2002, 32'h0, 32'h00F0_0000, 0);
    checks++; if (obs_rdata !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_data: got %h expected 000000f0", obs_rdata); end
    checks++; if (obs_rvalid !== 1'b1) begin errors++; $display("FAIL lbu_rvalid: got %b expected 1", obs_rvalid); end
    m_last = 32'h0000_00F0;
    $display("LBU addr=00002002 data=%h", obs_rdata);
  endtask

  task automatic test_lh_wait();
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0, 32'h8001_1234, 4);
    checks++; if (obs_stall !== 6) begin errors++; $display("FAIL lh_stall: got %0d expected 6", obs_stall); end
    checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", obs_rdata); end
    checks++; if (obs_req !== 5 || obs_stable !== 1'b1) begin errors++;
      $display("FAIL lh_req_stable: got req=%0d stable=%b expected req=5 stable=1", obs_req, obs_stable); end
    checks++; if (obs_addr !== 32'h0000_3000) begin errors++; $display("FAIL lh_addr: got %h expected 00003000", obs_addr); end
    m_last = 32'hFFFF_8001;
    $display("LH  addr=00003002 wait=4 data=%h stall=%0d", obs_rdata, obs_stall);
  endtask

  task automatic test_exc();
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h1234_5678, 32'h0, 0);
    checks++; if (obs_exc !== 1 || obs_req !== 0 || obs_stall !== 0) begin errors++;
      $display("FAIL sw_misaligned: got exc=%0d req=%0d stall=%0d expected 1/0/0", obs_exc, obs_req, obs_stall); end
    $display("SW  addr=00004002 exc=%0d", obs_exc);
    do_access(1'b0, 1'b1, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0);
    checks++; if (obs_exc !== 1 || obs_req !== 0 || obs_stall !== 0) begin errors++;
      $display("FAIL ld_illegal: got exc=%0d req=%0d stall=%0d expected 1/0/0", obs_exc, obs_req, obs_stall); end
    checks++; if (obs_rdata !== m_last) begin errors++; $display("FAIL exc_hold: got %h expected %h", obs_rdata, m_last); end
    $display("L011 addr=00004000 exc=%0d", obs_exc);
  endtask

  task automatic test_random();
    logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int t = 0; t < 40; t++) begin
      bit st, ld, eff_ld, valid, legal;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int w;
      st = 1'($urandom % 2);
      ld = st ? 1'($urandom % 2) : 1'(($urandom % 5) != 0);
      f3 = f3s[(t % 3 == 0) ? ($urandom % 8) : ($urandom % 5)];
      a  = $urandom; wd = $urandom; rd = $urandom;
      w  = $urandom_range(0, 3);
      eff_ld = !st && ld;
      valid  = st || eff_ld;
      legal  = m_legal(st, f3, a);
      do_access(st, ld, f3, a, wd, rd, w);
      if (valid && legal) begin
        if (eff_ld) m_last = m_load(f3, a, rd);
        checks++; if (obs_hung || obs_stall !== 2 + w || obs_req !== 1 + w || !obs_stable) begin errors++;
          $display("FAIL rnd_timing[%0d]: got stall=%0d req=%0d stable=%b expected %0d/%0d/1", t, obs_stall, obs_req, obs_stable, 2 + w, 1 + w); end
        checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_be !== m_be(st, f3, a) || obs_we !== st) begin errors++;
          $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b expected %h/%b/%b", t, obs_addr, obs_be, obs_we, {a[31:2], 2'b00}, m_be(st, f3, a), st); end
        if (st) begin
          checks++; if (obs_wdata !== m_wdata(f3, wd)) begin errors++;
            $display("FAIL rnd_wdata[%0d]: got %h expected %h", t, obs_wdata, m_wdata(f3, wd)); end
        end
        checks++; if (obs_rvalid !== eff_ld || obs_rdata !== m_last) begin errors++;
          $display("FAIL rnd_load[%0d]: got valid=%b data=%h expected %b/%h", t, obs_rvalid, obs_rdata, eff_ld, m_last); end
      end else begin
        checks++; if (obs_exc !== int'(valid) || obs_req !== 0 || obs_stall !== 0 || obs_rdata !== m_last) begin errors++;
          $display("FAIL rnd_reject[%0d]: got exc=%0d req=%0d stall=%0d data=%h expected %0d/0/0/%h", t, obs_exc, obs_req, obs_stall, obs_rdata, int'(valid), m_last); end
      end
      checks++; if (obs_buserr !== 0) begin errors++; $display("FAIL rnd_buserr[%0d]: got %0d expected 0", t, obs_buserr); end
      $display("RND %0d st=%b ld=%b f3=%b addr=%h wait=%0d exc=%0d data=%h", t, st, eff_ld, f3, a, w, obs_exc, obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int s1;
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0);
    s1 = obs_start;
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0, 32'h1357_9BDF, 0);
    checks++; if (obs_done - s1 !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d expected 5", obs_done - s1); end
    checks++; if (obs_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL b2b_data: got %h expected 13579bdf", obs_rdata); end
    m_last = 32'h1357_9BDF;
    $display("B2B SW->LW span=%0d data=%h", obs_done - s1, obs_rdata);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    memWriteM = 1'b0; resultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h40; dmem_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmid_enter: got req=%b expected 1", dmem_req); end
    rst = 1'b0; #1;
    checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b expected 0", stallM); end
    @(posedge clk); #1;
    checks++; if (dmem_req !== 1'b0 || readValidM !== 1'b0 || readDataM !== 32'h0) begin errors++;
      $display("FAIL rmid_abandon: got req=%b valid=%b data=%h expected 0/0/0", dmem_req, readValidM, readDataM); end
    drop_op();
    rst = 1'b1;
    m_last = 32'h0;
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1);
    checks++; if (obs_rdata !== 32'hDEAD_BEEF || obs_rvalid !== 1'b1 || obs_stall !== 3) begin errors++;
      $display("FAIL rmid_lw: got data=%h valid=%b stall=%0d expected deadbeef/1/3", obs_rdata, obs_rvalid, obs_stall); end
    m_last = 32'hDEAD_BEEF;
    $display("RMID LW addr=00000010 data=%h", obs_rdata);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, 1000);
    checks++; if (obs_hung || obs_req !== 8 || obs_stall !== 9) begin errors++;
      $display("FAIL tmo_len: got req=%0d stall=%0d expected 8/9", obs_req, obs_stall); end
    checks++; if (obs_buserr !== 1 || obs_rvalid !== 1'b0 || obs_rdata !== m_last) begin errors++;
      $display("FAIL tmo_err: got berr=%0d valid=%b data=%h expected 1/0/%h", obs_buserr, obs_rvalid, obs_rdata, m_last); end
    @(posedge clk); #1;
    checks++; if (busErrM !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", busErrM); end
    $display("TMO LW addr=00000020 req_cycles=%0d", obs_req);
  endtask
`else
  task automatic test_timeout();
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h0, 32'h1111_2222, 20);
    checks++; if (obs_hung || obs_stall !== 22 || obs_buserr !== 0 || obs_rdata !== 32'h1111_2222) begin errors++;
      $display("FAIL long_wait: got stall=%0d berr=%0d data=%h expected 22/0/11112222", obs_stall, obs_buserr, obs_rdata); end
    $display("WAIT LW addr=00000020 stall=%0d", obs_stall);
  endtask
`endif

  initial begin
    test_reset();
    test_sb();
    test_loads();
    test_lh_wait();
    test_exc();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_access.md
# mem_stage_access

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and drives the data-memory bus with a req/ready handshake. It decodes load/store size from funct3, generates byte enables and replicated write data, and aligns and extends load data. It holds the pipeline with `stallM` until the access completes. It sits between the EX/MEM register and the MEM/WB register.

## Interface
Parameters:
- `LOAD_SRC`, 2'b01: `resultSrcM` encoding that marks a load.
- `TIMEOUT_CYCLES`, 255: watchdog limit; used only with `MEM_TIMEOUT_EN`. Legal range 1..1023.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-low; sampled on posedge `clk`.
- `memWriteM` in 1: store request from EX/MEM.
- `resultSrcM` in 2: load when equal to `LOAD_SRC`.
- `funct3M` in 3: access size and signedness.
- `ALUResultM` in 32: byte address.
- `writeDataM` in 32: store data, with the value in the low bits.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{ALUResultM[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: replicated store data.
- `dmem_ready` in 1: bus completion for the current request.
- `dmem_rdata` in 32: read word; valid when `dmem_ready`=1.
- `stallM` out 1: hold the IF..M stages.
- `readDataM` out 32: aligned and extended load result.
- `readValidM` out 1: one-cycle pulse when `readDataM` is updated.
- `excM` out 1: one-cycle misaligned or illegal-size pulse.
- `busErrM` out 1: timeout pulse (only with `MEM_TIMEOUT_EN`, otherwise tied 0).

## Operation
- Operation valid when `memWriteM`=1 (store) or `resultSrcM`==`LOAD_SRC` (load). If both are set, the store wins.
- Size encoding:
  - `funct3M` 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Stores use only 000, 001, 010.
  - Any other encoding is illegal.
- Misaligned cases: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- Store formatting:
  - B: `be = 1<<addr[1:0]`; `wdata = {4{wd[7:0]}}`.
  - H: `be` = 0011 (`addr[1]`=0) or 1100 (`addr[1]`=1); `wdata = {2{wd[15:0]}}`.
  - W: `be` = 1111; `wdata = wd`.
- Load formatting: select the byte or half by `addr[1:0]`, then sign-extend (B, H) or zero-extend (BU, HU). Loads drive `be` = 1111.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, valid legal op: `stallM`=1 (combinational). At the edge, register addr/be/wdata/we/size/offset and go to ACCESS.
  - IDLE, valid illegal or misaligned op: no bus access; `excM`=1 this cycle (combinational); `stallM`=0; stay in IDLE. The store is suppressed.
  - ACCESS: `dmem_req`=1 and `stallM`=1. Bus outputs are held stable from the registered copy.
    - On an edge with `dmem_ready`=1, load the formatted `dmem_rdata` into `readDataM` (loads only) and go to DONE.
  - DONE: `dmem_req`=0 and `stallM`=0, so EX/MEM advances at this edge. `readValidM`=1 for loads. Next state is IDLE.
- `dmem_ready` is ignored outside ACCESS.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_req`, `dmem_we`, `readValidM`, `busErrM` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `readDataM` = 0.
  - Timeout counter = 0.
- Outputs while in reset: `stallM`=0 and `excM`=0 (reset gates the combinational paths).
- Registered outputs: `dmem_*`, `readDataM`, `readValidM`, `busErrM`.
- Combinational outputs: `stallM`, `excM`.
- Minimum occupancy is 3 cycles per access: IDLE, then ACCESS with `ready`=1, then DONE. Each extra wait cycle adds 1.
- `readDataM` holds its value until the next completed load.
- Reset asserted mid-ACCESS: `dmem_req` drops at that edge and the transaction is abandoned, with no `readValidM`.
- Ops arriving back-to-back after DONE are accepted in the following IDLE cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A 10-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `dmem_ready`=0.
  - On reaching `TIMEOUT_CYCLES`: drop `dmem_req`, pulse `busErrM` for 1 cycle, go to DONE with `readDataM` unchanged and `readValidM`=0.
- Undefined: no counter; ACCESS waits indefinitely; `busErrM` is constant 0.

## Test plan
- SB of `wd`=0x000000A5 to addr 0x1003 with `ready` at the first ACCESS cycle -> `be`=1000, `wdata`=0xA5A5A5A5, `addr`=0x1000, `stallM` high for 2 cycles, `we`=1.
- LB from 0x2002 with `rdata`=0x00F00000 -> `readDataM`=0xFFFFFFF0; LBU from the same address -> 0x000000F0; `readValidM` one-cycle pulse in DONE.
- LH from 0x3002 with `rdata`=0x8001_1234 and `ready` delayed 4 cycles -> `stallM` high for 6 cycles, `readDataM`=0xFFFF8001, `req` and address stable throughout.
- SW to 0x4002 -> `excM`=1 for 1 cycle, `dmem_req` never asserts, `stallM`=0; `funct3M`=011 load -> same behaviour.
- Reset driven low during ACCESS -> next edge `dmem_req`=0, state IDLE, no `readValidM`; a subsequent LW to 0x10 completes normally.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8 and `ready` held 0 -> `req` deasserts and `busErrM` pulses after 8 ACCESS cycles, `stallM` releases next cycle.
